// File: rtl/video_pkg.sv
// Shared definitions for the video active-area gate and its frame measurer.
// Holds the lock FSM encoding, counter widths and saturation limits, and
// small saturating-increment helpers used by the counters.
package video_pkg;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        LOCKING  = 2'd1,
        LOCKED   = 2'd2
    } lock_state_e;

    localparam int              PIX_CNT_W  = 12;
    localparam int              LINE_CNT_W = 9;
    localparam logic [11:0]     PIX_MAX    = 12'd4095;
    localparam logic [8:0]      LINE_MAX   = 9'd511;

    // Pixel counter increment that sticks at PIX_MAX instead of wrapping.
    function automatic logic [PIX_CNT_W-1:0] pix_sat_inc(input logic [PIX_CNT_W-1:0] v);
        logic [PIX_CNT_W-1:0] r;
        if (v == PIX_MAX) begin
            r = v;
        end else begin
            r = v + 12'd1;
        end
        return r;
    endfunction

    // Line counter increment that sticks at LINE_MAX instead of wrapping.
    function automatic logic [LINE_CNT_W-1:0] line_sat_inc(input logic [LINE_CNT_W-1:0] v);
        logic [LINE_CNT_W-1:0] r;
        if (v == LINE_MAX) begin
            r = v;
        end else begin
            r = v + 9'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/video_frame_measure.sv
// Measures the active picture of each frame.
//   clk32, reset_n, pause : clock, synchronous active-low reset, global freeze
//   ce_pix                : pixel enable; counts only while inside the active area
//   hblank_in, vblank_in  : blanking; a rising hblank closes a line
//   vsync_in              : a rising vsync closes the frame
//   cand_w, cand_h        : size of the frame being closed (valid with frame_done)
//   frame_done            : single-cycle strobe on the closing cycle (combinational,
//                           so the lock FSM updates on the very same clk32 edge)
module video_frame_measure
    import video_pkg::*;
(
    input  logic                  clk32,
    input  logic                  reset_n,
    input  logic                  pause,
    input  logic                  ce_pix,
    input  logic                  hblank_in,
    input  logic                  vblank_in,
    input  logic                  vsync_in,
    output logic [PIX_CNT_W-1:0]  cand_w,
    output logic [LINE_CNT_W-1:0] cand_h,
    output logic                  frame_done
);

    logic [PIX_CNT_W-1:0]  pix_cnt_q,  pix_cnt_d;
    logic [PIX_CNT_W-1:0]  line_max_q, line_max_d;
    logic [LINE_CNT_W-1:0] line_cnt_q, line_cnt_d;
    logic                  hblank_prev_q, hblank_prev_d;
    logic                  vsync_prev_q,  vsync_prev_d;

    logic                  de;
    logic                  hb_rise;
    logic                  vs_rise;
    logic [PIX_CNT_W-1:0]  pix_eff;
    logic [PIX_CNT_W-1:0]  line_max_eff;
    logic [LINE_CNT_W-1:0] line_cnt_eff;

    // Line and frame bookkeeping. The "_eff" values already include a pixel
    // or line closing in this cycle, so a coincident hblank/vsync rise folds
    // the last line into the frame that is being closed.
    always_comb begin
        de            = !hblank_in && !vblank_in;
        hb_rise       = hblank_in && !hblank_prev_q;
        vs_rise       = vsync_in  && !vsync_prev_q;
        pix_eff       = pix_cnt_q;
        line_max_eff  = line_max_q;
        line_cnt_eff  = line_cnt_q;
        pix_cnt_d     = pix_cnt_q;
        line_max_d    = line_max_q;
        line_cnt_d    = line_cnt_q;
        hblank_prev_d = hblank_in;
        vsync_prev_d  = vsync_in;

        if (ce_pix && de) begin
            pix_eff = pix_sat_inc(pix_cnt_q);
        end else begin
            pix_eff = pix_cnt_q;
        end

        if (hb_rise) begin
            // Empty lines (vertical blanking) are not counted.
            if (pix_eff != 12'd0) begin
                line_max_eff = (pix_eff > line_max_q) ? pix_eff : line_max_q;
                line_cnt_eff = line_sat_inc(line_cnt_q);
            end else begin
                line_max_eff = line_max_q;
                line_cnt_eff = line_cnt_q;
            end
            pix_cnt_d = 12'd0;
        end else begin
            pix_cnt_d = pix_eff;
        end

        if (vs_rise) begin
            line_max_d = 12'd0;
            line_cnt_d = 9'd0;
            pix_cnt_d  = 12'd0;
        end else begin
            line_max_d = line_max_eff;
            line_cnt_d = line_cnt_eff;
        end

        cand_w     = line_max_eff;
        cand_h     = line_cnt_eff;
        frame_done = vs_rise && !pause;
    end

    // Counter and edge-detector registers; pause freezes all of them.
    always_ff @(posedge clk32) begin
        if (!reset_n) begin
            pix_cnt_q     <= 12'd0;
            line_max_q    <= 12'd0;
            line_cnt_q    <= 9'd0;
            hblank_prev_q <= 1'b0;
            vsync_prev_q  <= 1'b0;
        end else if (!pause) begin
            pix_cnt_q     <= pix_cnt_d;
            line_max_q    <= line_max_d;
            line_cnt_q    <= line_cnt_d;
            hblank_prev_q <= hblank_prev_d;
            vsync_prev_q  <= vsync_prev_d;
        end else begin
            pix_cnt_q     <= pix_cnt_q;
            line_max_q    <= line_max_q;
            line_cnt_q    <= line_cnt_q;
            hblank_prev_q <= hblank_prev_q;
            vsync_prev_q  <= vsync_prev_q;
        end
    end

endmodule

// File: rtl/video_active_gate.sv
// Clean registered video bus for the scaler/OSD plus active-size lock.
//   clk32, reset_n, pause        : clock, synchronous active-low reset, freeze
//   ce_pix, r/g/b_in             : pixel enable and colour from the video chip
//   hsync/vsync/hblank/vblank_in : timing from video_sync
//   r/g/b_out                    : colour, black outside the active area
//   h/vsync_out, h/vblank_out    : timing delayed by one clk32
//   de_out, ce_pix_out           : data enable and pixel enable, one clk32 late
//   active_w, active_h           : last locked picture size (held when unlocked)
//   mode_stable                  : high while the size is locked
module video_active_gate
    import video_pkg::*;
#(
    parameter int DATA_W        = 8,
    parameter int STABLE_FRAMES = 4
) (
    input  logic              clk32,
    input  logic              reset_n,
    input  logic              pause,
    input  logic              ce_pix,
    input  logic [DATA_W-1:0] r_in,
    input  logic [DATA_W-1:0] g_in,
    input  logic [DATA_W-1:0] b_in,
    input  logic              hsync_in,
    input  logic              vsync_in,
    input  logic              hblank_in,
    input  logic              vblank_in,
    output logic [DATA_W-1:0] r_out,
    output logic [DATA_W-1:0] g_out,
    output logic [DATA_W-1:0] b_out,
    output logic              hsync_out,
    output logic              vsync_out,
    output logic              hblank_out,
    output logic              vblank_out,
    output logic              de_out,
    output logic              ce_pix_out,
    output logic [11:0]       active_w,
    output logic [8:0]        active_h,
    output logic              mode_stable
);

    localparam logic [4:0] SF_LIMIT = 5'(STABLE_FRAMES);
    localparam logic       SF_ONE   = (STABLE_FRAMES == 1);

    // Video path registers
    logic [DATA_W-1:0] r_q, r_d, g_q, g_d, b_q, b_d;
    logic              hsync_q, vsync_q, hblank_q, vblank_q, de_q, ce_q;
    logic              de_d;

    // Lock FSM registers
    lock_state_e       state_q, state_d;
    logic [11:0]       ref_w_q, ref_w_d;
    logic [8:0]        ref_h_q, ref_h_d;
    logic [3:0]        stab_q, stab_d;
    logic [11:0]       active_w_q, active_w_d;
    logic [8:0]        active_h_q, active_h_d;
    logic              mode_stable_q, mode_stable_d;

    logic [11:0]       cand_w;
    logic [8:0]        cand_h;
    logic              frame_done;

    video_frame_measure u_measure (
        .clk32      (clk32),
        .reset_n    (reset_n),
        .pause      (pause),
        .ce_pix     (ce_pix),
        .hblank_in  (hblank_in),
        .vblank_in  (vblank_in),
        .vsync_in   (vsync_in),
        .cand_w     (cand_w),
        .cand_h     (cand_h),
        .frame_done (frame_done)
    );

    // Colour gating: black whenever either blanking is active.
    always_comb begin
        de_d = !hblank_in && !vblank_in;
        r_d  = '0;
        g_d  = '0;
        b_d  = '0;
        if (de_d) begin
            r_d = r_in;
            g_d = g_in;
            b_d = b_in;
        end else begin
            r_d = '0;
            g_d = '0;
            b_d = '0;
        end
    end

    // Video path pipeline stage.
    always_ff @(posedge clk32) begin
        if (!reset_n) begin
            r_q      <= '0;
            g_q      <= '0;
            b_q      <= '0;
            hsync_q  <= 1'b0;
            vsync_q  <= 1'b0;
            hblank_q <= 1'b0;
            vblank_q <= 1'b0;
            de_q     <= 1'b0;
            ce_q     <= 1'b0;
        end else if (!pause) begin
            r_q      <= r_d;
            g_q      <= g_d;
            b_q      <= b_d;
            hsync_q  <= hsync_in;
            vsync_q  <= vsync_in;
            hblank_q <= hblank_in;
            vblank_q <= vblank_in;
            de_q     <= de_d;
            ce_q     <= ce_pix;
        end else begin
            r_q      <= r_q;
            g_q      <= g_q;
            b_q      <= b_q;
            hsync_q  <= hsync_q;
            vsync_q  <= vsync_q;
            hblank_q <= hblank_q;
            vblank_q <= vblank_q;
            de_q     <= de_q;
            ce_q     <= ce_q;
        end
    end

    logic        cand_nz;
    logic        cand_match;
    logic [4:0]  stab_inc;
    lock_state_e fresh_state;
    logic [3:0]  fresh_stab;
    logic        take_fresh;

    // Lock FSM. "fresh" is the UNLOCKED treatment of the current candidate;
    // a mismatch in LOCKED falls back to it within the same frame close.
    always_comb begin
        state_d     = state_q;
        ref_w_d     = ref_w_q;
        ref_h_d     = ref_h_q;
        stab_d      = stab_q;
        active_w_d  = active_w_q;
        active_h_d  = active_h_q;
        take_fresh  = 1'b0;
        cand_nz     = (cand_w != 12'd0) && (cand_h != 9'd0);
        cand_match  = (cand_w == ref_w_q) && (cand_h == ref_h_q);
        stab_inc    = {1'b0, stab_q} + 5'd1;

        if (cand_nz) begin
            fresh_state = SF_ONE ? LOCKED : LOCKING;
            fresh_stab  = 4'd1;
        end else begin
            fresh_state = UNLOCKED;
            fresh_stab  = 4'd0;
        end

        if (frame_done) begin
            case (state_q)
                UNLOCKED: begin
                    take_fresh = 1'b1;
                end
                LOCKING: begin
                    if (!cand_nz) begin
                        state_d = UNLOCKED;
                        stab_d  = 4'd0;
                    end else if (cand_match) begin
                        stab_d = stab_inc[3:0];
                        if (stab_inc >= SF_LIMIT) begin
                            state_d    = LOCKED;
                            active_w_d = ref_w_q;
                            active_h_d = ref_h_q;
                        end else begin
                            state_d = LOCKING;
                        end
                    end else begin
                        take_fresh = 1'b1;
                    end
                end
                LOCKED: begin
                    if (cand_match) begin
                        state_d = LOCKED;
                    end else begin
                        take_fresh = 1'b1;
                    end
                end
                default: begin
                    state_d = UNLOCKED;
                    stab_d  = 4'd0;
                end
            endcase
        end else begin
            state_d = state_q;
        end

        if (take_fresh) begin
            state_d = fresh_state;
            stab_d  = fresh_stab;
            if (cand_nz) begin
                ref_w_d = cand_w;
                ref_h_d = cand_h;
            end else begin
                ref_w_d = ref_w_q;
                ref_h_d = ref_h_q;
            end
            if (fresh_state == LOCKED) begin
                active_w_d = cand_w;
                active_h_d = cand_h;
            end else begin
                active_w_d = active_w_q;
                active_h_d = active_h_q;
            end
        end else begin
            take_fresh = 1'b0;
        end

        mode_stable_d = (state_d == LOCKED);
    end

    // Lock FSM state and lock outputs; updated together so mode_stable
    // changes on the same edge as the state.
    always_ff @(posedge clk32) begin
        if (!reset_n) begin
            state_q       <= UNLOCKED;
            ref_w_q       <= 12'd0;
            ref_h_q       <= 9'd0;
            stab_q        <= 4'd0;
            active_w_q    <= 12'd0;
            active_h_q    <= 9'd0;
            mode_stable_q <= 1'b0;
        end else if (!pause) begin
            state_q       <= state_d;
            ref_w_q       <= ref_w_d;
            ref_h_q       <= ref_h_d;
            stab_q        <= stab_d;
            active_w_q    <= active_w_d;
            active_h_q    <= active_h_d;
            mode_stable_q <= mode_stable_d;
        end else begin
            state_q       <= state_q;
            ref_w_q       <= ref_w_q;
            ref_h_q       <= ref_h_q;
            stab_q        <= stab_q;
            active_w_q    <= active_w_q;
            active_h_q    <= active_h_q;
            mode_stable_q <= mode_stable_q;
        end
    end

    assign r_out       = r_q;
    assign g_out       = g_q;
    assign b_out       = b_q;
    assign hsync_out   = hsync_q;
    assign vsync_out   = vsync_q;
    assign hblank_out  = hblank_q;
    assign vblank_out  = vblank_q;
    assign de_out      = de_q;
    assign ce_pix_out  = ce_q;
    assign active_w    = active_w_q;
    assign active_h    = active_h_q;
    assign mode_stable = mode_stable_q;

endmodule
